multi_cycle_control: RTL
========================

MULTI_CYCLE_CONTROL -- requirements
Module: multi_cycle_control

Interface
REQ-001 Parameter: CNT_W, default 32, width of the performance counters.
REQ-002 Port: clk  in  1  rising-edge clock.
REQ-003 Port: rst_n  in  1  asynchronous reset, active-low.
REQ-004 Port: opcode  in  6  instruction[31:26] from the instruction register.
REQ-005 Port: funct  in  6  instruction[5:0].
REQ-006 Port: mem_ready  in  1  memory access complete this cycle.
REQ-007 Ports, all out 1: pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a.
REQ-008 Ports: alu_src_b  out  2; pc_source  out  2; alu_ctrl  out  4.
REQ-009 Port: bad_op  out  1  one-cycle pulse on an unsupported opcode.
REQ-010 Ports: instr_count, cycle_count  out  CNT_W  retired instructions and elapsed cycles.

Function
REQ-011 Moore FSM with states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTEXE, ALUWB, BRANCH, ADDIEXE, ADDIWB, JUMP.
REQ-012 FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, ALUOp=add, pc_source=00. ir_write=pc_write=mem_ready. Go to DECODE on mem_ready, else stay.
REQ-013 DECODE: alu_src_a=0, alu_src_b=11, ALUOp=add. Next state by opcode: 100011/101011->MEMADR, 000000->RTEXE, 000100/000101->BRANCH, 001000->ADDIEXE, 000010->JUMP. Any other opcode->FETCH with bad_op=1 for exactly that cycle.
REQ-014 MEMADR: alu_src_a=1, alu_src_b=10, ALUOp=add. lw->MEMRD, sw->MEMWR.
REQ-015 MEMRD: mem_read=1, i_or_d=1. Waits for mem_ready, then MEMWB.
REQ-016 MEMWR: mem_write=1, i_or_d=1. Waits for mem_ready, then FETCH.
REQ-017 MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1; then FETCH.
REQ-018 RTEXE: alu_src_a=1, alu_src_b=00, ALUOp=funct; then ALUWB. ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0; then FETCH.
REQ-019 BRANCH: alu_src_a=1, alu_src_b=00, ALUOp=sub, pc_write_cond=1, pc_source=01, branch_ne=(opcode==000101); then FETCH.
REQ-020 ADDIEXE: alu_src_a=1, alu_src_b=10, ALUOp=add; then ADDIWB. ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0; then FETCH.
REQ-021 JUMP: pc_write=1, pc_source=10; then FETCH.
REQ-022 Any output not listed for a state is 0. mem_read and mem_write are never both 1.
REQ-023 alu_ctrl codes: ALUOp=add->0010, sub->0110. ALUOp=funct maps 100000->0010, 100010->0110, 100100->0000, 100101->0001, 101010->0111; any other funct->0010.
REQ-024 instr_count increments by 1, wrapping, on every transition into FETCH from MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB or JUMP. A bad_op return does not count.
REQ-025 cycle_count increments by 1 on every clock with rst_n high, wrapping at 2^CNT_W.

Reset
REQ-026 rst_n low asynchronously forces state=FETCH, instr_count=0 and cycle_count=0.
REQ-027 While rst_n is low, all write/enable outputs (pc_write, pc_write_cond, ir_write, mem_read, mem_write, reg_write) and bad_op are forced to 0, regardless of mem_ready.
REQ-028 Reset asserted mid-instruction abandons that instruction with no retire count. After release, operation resumes at FETCH on the next rising edge.

Structure
REQ-029 Shared include mips_defs holds opcode constants, state encodings, ALUOp codes (add=00, sub=01, funct=10) and alu_ctrl codes, for reuse by the datapath and the pipelined core.
REQ-030 One sub-module, alu_control (ALUOp, funct -> alu_ctrl), is purely combinational and instantiated once.

Verification
REQ-031 Reset, then mem_ready=1 and an R-type add (funct 100000): states FETCH, DECODE, RTEXE, ALUWB, FETCH; alu_ctrl=0010 in RTEXE; instr_count=1 after 4 cycles.
REQ-032 lw with mem_ready held low for 3 cycles in MEMRD: FSM stays in MEMRD for those 3 cycles, then 1 cycle later reaches MEMWB with reg_write=1, mem_to_reg=1; lw total = 8 cycles.
REQ-033 beq versus bne: pc_write_cond=1 in BRANCH for both; branch_ne=0 for beq, branch_ne=1 for bne; each retires in 3 cycles.
REQ-034 opcode 111111: bad_op=1 for 1 cycle in DECODE, next state FETCH, instr_count unchanged.
REQ-035 rst_n pulled low in MEMWR mid-cycle: mem_write drops immediately, state=FETCH, both counters read 0.
REQ-036 CNT_W=4, run 16 jumps (3 cycles each): instr_count wraps to 0 and cycle_count wraps at every 16 cycles.

Source files
------------

// File: rtl/mips_defs.sv
// rtl/mips_defs.sv - opcode, state, ALUOp and alu_ctrl encodings shared by the MIPS control and datapath
package mips_defs;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTEXE   = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEXE = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

endpackage

// File: rtl/alu_control.sv
// rtl/alu_control.sv - combinational ALUOp/funct to alu_ctrl decoder
// Ports: alu_op (2, ALUOp code), funct (6, instruction[5:0]) -> alu_ctrl (4)
module alu_control
    import mips_defs::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output logic [3:0] alu_ctrl
);

    always_comb begin
        alu_ctrl = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_ctrl = ALU_ADD;
            ALUOP_SUB: alu_ctrl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  alu_ctrl = ALU_ADD;
                    FN_SUB:  alu_ctrl = ALU_SUB;
                    FN_AND:  alu_ctrl = ALU_AND;
                    FN_OR:   alu_ctrl = ALU_OR;
                    FN_SLT:  alu_ctrl = ALU_SLT;
                    default: alu_ctrl = ALU_ADD;
                endcase
            end
            default: alu_ctrl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multi_cycle_control.sv
// rtl/multi_cycle_control.sv - multi-cycle MIPS control FSM with retire and cycle counters
// Ports: clk, rst_n (async, active-low), opcode/funct from the IR, mem_ready;
//        datapath controls (pc_write .. alu_ctrl), bad_op pulse, instr_count/cycle_count.
module multi_cycle_control
    import mips_defs::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             branch_ne,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             mem_to_reg,
    output logic             reg_dst,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       pc_source,
    output logic [3:0]       alu_ctrl,
    output logic             bad_op,
    output logic [CNT_W-1:0] instr_count,
    output logic [CNT_W-1:0] cycle_count
);

    state_t state, next_state;
    aluop_t alu_op;
    logic   pc_write_s, pc_write_cond_s, mem_read_s, mem_write_s;
    logic   ir_write_s, reg_write_s, bad_op_s, retire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_FETCH;
            instr_count <= '0;
            cycle_count <= '0;
        end else begin
            state       <= next_state;
            cycle_count <= cycle_count + CNT_W'(1);
            if (retire) begin
                instr_count <= instr_count + CNT_W'(1);
            end
        end
    end

    always_comb begin
        next_state      = state;
        pc_write_s      = 1'b0;
        pc_write_cond_s = 1'b0;
        mem_read_s      = 1'b0;
        mem_write_s     = 1'b0;
        ir_write_s      = 1'b0;
        reg_write_s     = 1'b0;
        bad_op_s        = 1'b0;
        branch_ne       = 1'b0;
        i_or_d          = 1'b0;
        mem_to_reg      = 1'b0;
        reg_dst         = 1'b0;
        alu_src_a       = 1'b0;
        alu_src_b       = 2'b00;
        pc_source       = 2'b00;
        alu_op          = ALUOP_ADD;
        retire          = 1'b0;
        case (state)
            S_FETCH: begin
                mem_read_s = 1'b1;
                alu_src_b  = 2'b01;
                ir_write_s = mem_ready;
                pc_write_s = mem_ready;
                if (mem_ready) next_state = S_DECODE;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    OP_LW, OP_SW:   next_state = S_MEMADR;
                    OP_RTYPE:       next_state = S_RTEXE;
                    OP_BEQ, OP_BNE: next_state = S_BRANCH;
                    OP_ADDI:        next_state = S_ADDIEXE;
                    OP_J:           next_state = S_JUMP;
                    default: begin
                        bad_op_s   = 1'b1;
                        next_state = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                next_state = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                mem_read_s = 1'b1;
                i_or_d     = 1'b1;
                if (mem_ready) next_state = S_MEMWB;
            end
            S_MEMWR: begin
                mem_write_s = 1'b1;
                i_or_d      = 1'b1;
                if (mem_ready) begin
                    next_state = S_FETCH;
                    retire     = 1'b1;
                end
            end
            S_MEMWB: begin
                reg_write_s = 1'b1;
                mem_to_reg  = 1'b1;
                next_state  = S_FETCH;
                retire      = 1'b1;
            end
            S_RTEXE: begin
                alu_src_a  = 1'b1;
                alu_op     = ALUOP_FUNCT;
                next_state = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_s = 1'b1;
                reg_dst     = 1'b1;
                next_state  = S_FETCH;
                retire      = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a       = 1'b1;
                alu_op          = ALUOP_SUB;
                pc_write_cond_s = 1'b1;
                pc_source       = 2'b01;
                branch_ne       = (opcode == OP_BNE);
                next_state      = S_FETCH;
                retire          = 1'b1;
            end
            S_ADDIEXE: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                next_state = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write_s = 1'b1;
                next_state  = S_FETCH;
                retire      = 1'b1;
            end
            S_JUMP: begin
                pc_write_s = 1'b1;
                pc_source  = 2'b10;
                next_state = S_FETCH;
                retire     = 1'b1;
            end
            default: next_state = S_FETCH;
        endcase
    end

    // Enables are gated by rst_n so nothing writes while reset is held,
    // even though the reset state (FETCH) would otherwise request a read.
    assign pc_write      = pc_write_s & rst_n;
    assign pc_write_cond = pc_write_cond_s & rst_n;
    assign mem_read      = mem_read_s & rst_n;
    assign mem_write     = mem_write_s & rst_n;
    assign ir_write      = ir_write_s & rst_n;
    assign reg_write     = reg_write_s & rst_n;
    assign bad_op        = bad_op_s & rst_n;

    alu_control u_alu_control (
        .alu_op   (alu_op),
        .funct    (funct),
        .alu_ctrl (alu_ctrl)
    );

endmodule
